coms_update_scheduler: RTL and testbench

Sequences control-mode and setpoint update transactions from the Avalon register block onto the shared UART link to the iCE motor boards. Per-motor requests are collected as sticky pending bits and granted one at a time: mode requests before setpoint requests, round-robin within each class. A grant drives the link's `trigger_*` / `motor_to_update` inputs and then tracks link occupancy through `link_busy`. An optional periodic sweep re-sends every motor's setpoint.

---
 rtl/coms_update_scheduler_if.sv | 32 +++
 rtl/coms_update_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_coms_update_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coms_update_scheduler_if.sv
// Signal bundle between the register block / UART link side (master) and the
// update scheduler (slave).
interface coms_update_scheduler_if #(
  parameter int NUMBER_OF_MOTORS = 6
);
  logic [NUMBER_OF_MOTORS-1:0] mode_req;
  logic [NUMBER_OF_MOTORS-1:0] sp_req;
  logic [31:0]                 sp_period_cycles;
  logic                        link_busy;
  logic                        trigger_control_mode_update;
  logic                        trigger_setpoint_update;
  logic [7:0]                  motor_to_update;
  logic [NUMBER_OF_MOTORS-1:0] pending_mode;
  logic [NUMBER_OF_MOTORS-1:0] pending_sp;
  logic [15:0]                 merged_count;
  logic [15:0]                 timeout_count;

  // Grant handshake: a trigger_* pulse is a one-cycle grant with no ready
  // signal. The link acknowledges by raising link_busy and finishes the frame
  // by dropping it; only then may the next grant be issued.
  modport master (
    output mode_req, sp_req, sp_period_cycles, link_busy,
    input  trigger_control_mode_update, trigger_setpoint_update, motor_to_update,
    input  pending_mode, pending_sp, merged_count, timeout_count
  );

  modport slave (
    input  mode_req, sp_req, sp_period_cycles, link_busy,
    output trigger_control_mode_update, trigger_setpoint_update, motor_to_update,
    output pending_mode, pending_sp, merged_count, timeout_count
  );
endinterface

// File: rtl/coms_update_scheduler.sv
// Serialises per-motor mode/setpoint updates onto the shared UART link.
// Optional acknowledge timeout with retry is enabled by defining SCHED_TIMEOUT_EN.
module coms_update_scheduler #(
  parameter int NUMBER_OF_MOTORS   = 6,
  parameter int ACK_TIMEOUT_CYCLES = 4800
) (
  input  logic                   clk,
  input  logic                   reset,
  coms_update_scheduler_if.slave bus,
  output logic [1:0]             state_o
);
  localparam int         N         = NUMBER_OF_MOTORS;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  localparam logic [7:0] LAST_IDX  = 8'(N - 1);

  logic [1:0]  state_q, state_d;
  logic [N-1:0] pend_mode_q, pend_mode_d;
  logic [N-1:0] pend_sp_q, pend_sp_d;
  logic [7:0]  ptr_mode_q, ptr_mode_d;
  logic [7:0]  ptr_sp_q, ptr_sp_d;
  logic [7:0]  motor_q, motor_d;
  logic        trig_mode_q, trig_mode_d;
  logic        trig_sp_q, trig_sp_d;
  logic [15:0] merged_q, merged_d;
  logic [31:0] sweep_q, sweep_d;
  logic        sweep_fire;

  logic         pick_mode;
  logic         grant_found;
  logic [N-1:0] cls_vec;
  logic [N-1:0] rot_vec;
  logic [N-1:0] grant_oh;
  logic [7:0]   cls_ptr;
  logic [7:0]   grant_idx;
  int           sum_v;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT_CYCLES - 1);
  logic [31:0]  timer_q, timer_d;
  logic [15:0]  tmo_q, tmo_d;
  logic         gnt_mode_q, gnt_mode_d;
  logic [N-1:0] gnt_oh_q, gnt_oh_d;
  logic         retry;
`endif

  // Rotate the class vector so the pointer sits at bit 0; the lowest set bit
  // of the rotated vector is the circular first-at-or-after match.
  always_comb begin
    pick_mode   = |pend_mode_q;
    cls_vec     = pick_mode ? pend_mode_q : pend_sp_q;
    cls_ptr     = pick_mode ? ptr_mode_q : ptr_sp_q;
    rot_vec     = NUMBER_OF_MOTORS'({cls_vec, cls_vec} >> cls_ptr);
    grant_found = 1'b0;
    sum_v       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_vec[k]) begin
        grant_found = 1'b1;
        sum_v       = int'(cls_ptr) + k;
      end
    end
    if (sum_v >= N) sum_v = sum_v - N;
    grant_idx   = 8'(sum_v);
    grant_oh    = '0;
    grant_oh[0] = 1'b1;
    grant_oh    = grant_oh << grant_idx;
  end

  always_comb begin
    state_d     = state_q;
    pend_mode_d = pend_mode_q;
    pend_sp_d   = pend_sp_q;
    ptr_mode_d  = ptr_mode_q;
    ptr_sp_d    = ptr_sp_q;
    motor_d     = motor_q;
    trig_mode_d = 1'b0;
    trig_sp_d   = 1'b0;
    merged_d    = merged_q;
    sweep_d     = sweep_q;
    sweep_fire  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    timer_d     = timer_q;
    tmo_d       = tmo_q;
    gnt_mode_d  = gnt_mode_q;
    gnt_oh_d    = gnt_oh_q;
    retry       = 1'b0;
`endif

    if (bus.sp_period_cycles == 32'd0) begin
      sweep_d = '0;
    end else if (sweep_q >= bus.sp_period_cycles - 32'd1) begin
      sweep_fire = 1'b1;
      sweep_d    = '0;
    end else begin
      sweep_d = sweep_q + 32'd1;
    end

    if ((((bus.mode_req & pend_mode_q) != '0) || ((bus.sp_req & pend_sp_q) != '0))
        && (merged_q != 16'hFFFF)) begin
      merged_d = merged_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = ISSUE;
          motor_d = grant_idx;
          if (pick_mode) begin
            trig_mode_d = 1'b1;
            pend_mode_d = pend_mode_q & ~grant_oh;
            ptr_mode_d  = (grant_idx == LAST_IDX) ? 8'd0 : grant_idx + 8'd1;
          end else begin
            trig_sp_d = 1'b1;
            pend_sp_d = pend_sp_q & ~grant_oh;
            ptr_sp_d  = (grant_idx == LAST_IDX) ? 8'd0 : grant_idx + 8'd1;
          end
`ifdef SCHED_TIMEOUT_EN
          timer_d    = '0;
          gnt_mode_d = pick_mode;
          gnt_oh_d   = grant_oh;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
`ifdef SCHED_TIMEOUT_EN
        timer_d = timer_q + 32'd1;
`endif
      end
      WAIT_BUSY: begin
        if (bus.link_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (timer_q >= TMO_LAST) begin
          state_d = IDLE;
          retry   = 1'b1;
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.link_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // New requests and the sweep are applied after the grant clear so they win.
    pend_mode_d = pend_mode_d | bus.mode_req;
    pend_sp_d   = pend_sp_d | bus.sp_req | {N{sweep_fire}};
`ifdef SCHED_TIMEOUT_EN
    if (retry) begin
      if (gnt_mode_q) pend_mode_d = pend_mode_d | gnt_oh_q;
      else            pend_sp_d   = pend_sp_d | gnt_oh_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_mode_q <= '0;
      pend_sp_q   <= '0;
      ptr_mode_q  <= '0;
      ptr_sp_q    <= '0;
      motor_q     <= '0;
      trig_mode_q <= 1'b0;
      trig_sp_q   <= 1'b0;
      merged_q    <= '0;
      sweep_q     <= '0;
`ifdef SCHED_TIMEOUT_EN
      timer_q     <= '0;
      tmo_q       <= '0;
      gnt_mode_q  <= 1'b0;
      gnt_oh_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_mode_q <= pend_mode_d;
      pend_sp_q   <= pend_sp_d;
      ptr_mode_q  <= ptr_mode_d;
      ptr_sp_q    <= ptr_sp_d;
      motor_q     <= motor_d;
      trig_mode_q <= trig_mode_d;
      trig_sp_q   <= trig_sp_d;
      merged_q    <= merged_d;
      sweep_q     <= sweep_d;
`ifdef SCHED_TIMEOUT_EN
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      gnt_mode_q  <= gnt_mode_d;
      gnt_oh_q    <= gnt_oh_d;
`endif
    end
  end

  assign bus.trigger_control_mode_update = trig_mode_q;
  assign bus.trigger_setpoint_update     = trig_sp_q;
  assign bus.motor_to_update             = motor_q;
  assign bus.pending_mode                = pend_mode_q;
  assign bus.pending_sp                  = pend_sp_q;
  assign bus.merged_count                = merged_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_count               = tmo_q;
`else
  assign bus.timeout_count               = '0;
`endif
  assign state_o                         = state_q;

endmodule

// File: tb/tb_coms_update_scheduler.sv
// Bench for coms_update_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_coms_update_scheduler;
  localparam int N   = 6;
  localparam int ACK = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  coms_update_scheduler_if #(.NUMBER_OF_MOTORS(N)) bus ();

  coms_update_scheduler #(
    .NUMBER_OF_MOTORS  (N),
    .ACK_TIMEOUT_CYCLES(ACK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] log_exp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit     m_pm[N];
  bit     m_ps[N];
  int     m_ptr_m, m_ptr_s, m_merged, m_tmo, m_age, m_motor;
  longint m_sweep;
  bit     m_in_txn, m_just, m_seen, m_cls;
  bit     e_tm, e_ts;

  function automatic logic [N-1:0] pack(input bit a[N]);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_edge();
    bit hit, fire, cls, retry;
    int g, idx;
    e_tm = 1'b0;
    e_ts = 1'b0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pm[i] = 1'b0;
        m_ps[i] = 1'b0;
      end
      m_ptr_m = 0; m_ptr_s = 0; m_merged = 0; m_tmo = 0; m_age = 0; m_motor = 0;
      m_sweep = 0; m_in_txn = 0; m_just = 0; m_seen = 0; m_cls = 0;
      return;
    end
    hit = 0;
    for (int i = 0; i < N; i++)
      if ((bus.mode_req[i] && m_pm[i]) || (bus.sp_req[i] && m_ps[i])) hit = 1;
    if (hit && m_merged < 65535) m_merged++;

    fire = 0;
    if (bus.sp_period_cycles == 0) m_sweep = 0;
    else if (m_sweep + 1 >= longint'(bus.sp_period_cycles)) begin
      fire    = 1;
      m_sweep = 0;
    end else m_sweep++;

    retry = 0;
    if (!m_in_txn) begin
      cls = 0;
      for (int i = 0; i < N; i++) if (m_pm[i]) cls = 1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = ((cls ? m_ptr_m : m_ptr_s) + k) % N;
        if (g < 0 && (cls ? m_pm[idx] : m_ps[idx])) g = idx;
      end
      if (g >= 0) begin
        m_in_txn = 1; m_just = 1; m_seen = 0; m_age = 0; m_motor = g; m_cls = cls;
        if (cls) begin
          m_pm[g] = 0; m_ptr_m = (g + 1) % N; e_tm = 1;
        end else begin
          m_ps[g] = 0; m_ptr_s = (g + 1) % N; e_ts = 1;
        end
        exp_q.push_back({cls, 8'(g)});
      end
    end else if (m_just) begin
      m_just = 0;
      m_age  = 1;
    end else if (!m_seen) begin
      if (bus.link_busy) m_seen = 1;
`ifdef SCHED_TIMEOUT_EN
      else if (m_age + 1 >= ACK) begin
        m_in_txn = 0;
        retry    = 1;
        if (m_tmo < 65535) m_tmo++;
      end else m_age++;
`endif
    end else if (!bus.link_busy) begin
      m_in_txn = 0;
    end

    for (int i = 0; i < N; i++) begin
      if (bus.mode_req[i]) m_pm[i] = 1;
      if (bus.sp_req[i] || fire) m_ps[i] = 1;
    end
    if (retry) begin
      if (m_cls) m_pm[m_motor] = 1;
      else       m_ps[m_motor] = 1;
    end
  endtask

  task automatic compare();
    logic [8:0] e;
    check("trig_mode", bus.trigger_control_mode_update, e_tm);
    check("trig_sp",   bus.trigger_setpoint_update, e_ts);
    check("motor",     bus.motor_to_update, m_motor);
    check("pend_mode", bus.pending_mode, pack(m_pm));
    check("pend_sp",   bus.pending_sp, pack(m_ps));
    check("merged",    bus.merged_count, m_merged);
    check("timeouts",  bus.timeout_count, m_tmo);
    if (bus.trigger_control_mode_update || bus.trigger_setpoint_update) begin
      got_q.push_back({bus.trigger_control_mode_update, bus.motor_to_update});
      check("sb_depth", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_grant", {bus.trigger_control_mode_update, bus.motor_to_update}, e);
      end
    end
  endtask

  // ---------------- link responder ----------------
  // mode 0 random, 1 slow fixed, 2 fast, 3 stuck idle
  int lk_mode = 0;
  int lk_wait = 0;
  int lk_len  = 0;

  task automatic drive_link();
    if (e_tm || e_ts) begin
      case (lk_mode)
        1:       begin lk_wait = 3; lk_len = 3; end
        2:       begin lk_wait = 0; lk_len = 2; end
        3:       begin lk_wait = 0; lk_len = 0; end
        default: begin lk_wait = $urandom_range(0, 3); lk_len = $urandom_range(2, 4); end
      endcase
    end
    if (lk_mode == 3) bus.link_busy = 1'b0;
    else if (lk_wait > 0) begin lk_wait--; bus.link_busy = 1'b0; end
    else if (lk_len > 0) begin lk_len--; bus.link_busy = 1'b1; end
    else bus.link_busy = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    drive_link();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input logic [N-1:0] m, input logic [N-1:0] s);
    bus.mode_req = m;
    bus.sp_req   = s;
    cycle();
    bus.mode_req = '0;
    bus.sp_req   = '0;
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus.mode_req         = '0;
    bus.sp_req           = '0;
    bus.sp_period_cycles = '0;
    bus.link_busy        = 1'b0;
    lk_wait              = 0;
    lk_len               = 0;
    cycle();
    cycle();
    reset = 1'b0;
    got_q.delete();
    log_exp.delete();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, got_q.size(), log_exp.size());
    for (int i = 0; i < log_exp.size() && i < got_q.size(); i++)
      check(tag, got_q[i], log_exp[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // single setpoint request, slow link
    lk_mode = 1;
    do_reset();
    check("rst_state", state_dbg, 2'd0);
    check("rst_motor", bus.motor_to_update, 8'd0);
    pulse('0, 6'b000100);
    run(15);
    log_exp.push_back({1'b0, 8'd2});
    check_log("t1_grants");
    check("t1_pend_sp", bus.pending_sp, '0);

    // mode before setpoint on the same motor
    do_reset();
    pulse(6'b000001, 6'b000001);
    run(30);
    log_exp.push_back({1'b1, 8'd0});
    log_exp.push_back({1'b0, 8'd0});
    check_log("t2_grants");

    // round-robin order, fast link
    lk_mode = 2;
    do_reset();
    pulse('0, 6'b111111);
    run(30);
    for (int i = 0; i < N; i++) log_exp.push_back({1'b0, 8'(i)});
    check_log("t3a_grants");
    got_q.delete();
    log_exp.delete();
    pulse('0, 6'b100001);
    run(12);
    log_exp.push_back({1'b0, 8'd0});
    log_exp.push_back({1'b0, 8'd5});
    check_log("t3b_grants");

    // merge while the link is occupied
    lk_mode = 1;
    do_reset();
    pulse(6'b000001, '0);
    pulse('0, 6'b001000);
    cycle();
    pulse('0, 6'b001000);
    run(30);
    check("t4_merged", bus.merged_count, 16'd1);
    log_exp.push_back({1'b1, 8'd0});
    log_exp.push_back({1'b0, 8'd3});
    check_log("t4_grants");

    // periodic sweep
    lk_mode = 2;
    do_reset();
    bus.sp_period_cycles = 32'd100;
    run(340);
    bus.sp_period_cycles = 32'd0;
    run(5);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) log_exp.push_back({1'b0, 8'(i)});
    check_log("t5_sweep");

    // link never acknowledges
    lk_mode = 3;
    do_reset();
    pulse(6'b000010, '0);
`ifdef SCHED_TIMEOUT_EN
    run(ACK + 2);
    check("t6_timeouts", bus.timeout_count, 16'd1);
    check("t6_regrants", got_q.size(), 2);
    run(ACK);
`else
    run(60);
    check("t6_stuck", state_dbg != 2'd0, 1'b1);
    check("t6_grants", got_q.size(), 1);
    check("t6_timeouts", bus.timeout_count, 16'd0);
`endif

    // random traffic
    lk_mode = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.mode_req = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      bus.sp_req   = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 199) == 0)
        bus.sp_period_cycles = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(5, 90));
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end
    reset        = 1'b0;
    bus.mode_req = '0;
    bus.sp_req   = '0;
    bus.sp_period_cycles = '0;
    run(40);
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
